uart_row_sender: RTL and testbench

UART_ROW_SENDER -- requirements
Module: uart_row_sender

---
 rtl/uart_row_pkg.sv | 27 ++
 rtl/uart_row_sender_neg.sv | 25 ++
 rtl/uart_row_sender.sv | 191 +++++++++++++++++++
 tb/tb_uart_row_sender.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_row_pkg.sv
// uart_row_pkg: definitions shared by the row sender and the receiving
// controller at the other end of the link.
//   state_t               - sender frame state machine states
//   END_WORD              - frame terminator byte
//   SUCCESSFULLY_RECEIVED - ACK byte returned by the receiver
//   NOT_ALL_RECEIVED      - NAK byte returned by the receiver
//   row_byte()            - splits the 9-bit row number into its two header bytes
package uart_row_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SEND     = 3'd2,
        WAIT_TX  = 3'd3,
        WAIT_ACK = 3'd4
    } state_t;

    localparam logic [7:0] END_WORD              = 8'hDD;
    localparam logic [7:0] SUCCESSFULLY_RECEIVED = 8'hFF;
    localparam logic [7:0] NOT_ALL_RECEIVED      = 8'h11;

    // Header byte 0 carries row[8] in its LSB, header byte 1 carries row[7:0].
    function automatic logic [7:0] row_byte(input logic [8:0] r, input logic high_part);
        return high_part ? {7'b0, r[8]} : r[7:0];
    endfunction

endpackage

// File: rtl/uart_row_sender_neg.sv
// neg: falling-edge detector.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   sig   - monitored level
//   fall  - high for the cycle in which sig is low after being high the cycle before
module neg (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic fall
);

    logic sig_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_prev <= 1'b0;
        end else begin
            sig_prev <= sig;
        end
    end

    assign fall = sig_prev & ~sig;

endmodule

// File: rtl/uart_row_sender.sv
// uart_row_sender: sends one row frame over a byte UART and waits for the
// receiver's ACK/NAK, resending the whole frame on NAK or response timeout.
// Frame: {7'b0,row[8]}, row[7:0], payload[0..PAYLOAD_BYTES-1], END_WORD.
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   start, row          - one-cycle row request, row number latched on acceptance
//   rd_addr, rd_data    - payload buffer port, data valid one cycle after address
//   tx_data, tx_start   - byte and one-cycle strobe to the UART transmitter
//   tx_busy             - transmitter busy
//   rx_data, rx_done    - byte and one-cycle strobe from the UART receiver
//   busy                - frame in progress
//   done, error         - one-cycle outcome pulses (ACK received / retries exhausted)
//   retries             - transmissions beyond the first for the current row
//
// Handshake with the transmitter: tx_start is a single-cycle strobe issued
// only while tx_busy is low; the byte counts as handed over once tx_busy has
// risen and then fallen again, and only then is the next byte prepared.
module uart_row_sender #(
    parameter int         PAYLOAD_BYTES         = 240,
    parameter logic [7:0] END_WORD              = uart_row_pkg::END_WORD,
    parameter logic [7:0] SUCCESSFULLY_RECEIVED = uart_row_pkg::SUCCESSFULLY_RECEIVED,
    parameter logic [7:0] NOT_ALL_RECEIVED      = uart_row_pkg::NOT_ALL_RECEIVED,
    parameter int         MAX_RETRY             = 3,
    parameter int         ACK_TIMEOUT           = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] row,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] retries
);

    import uart_row_pkg::state_t;
    import uart_row_pkg::IDLE;
    import uart_row_pkg::LOAD;
    import uart_row_pkg::SEND;
    import uart_row_pkg::WAIT_TX;
    import uart_row_pkg::WAIT_ACK;
    import uart_row_pkg::row_byte;

    // Index of the END_WORD byte; the counter stops here and never wraps.
    localparam logic [7:0] LAST_IDX   = 8'(PAYLOAD_BYTES + 2);
    localparam int         TW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [7:0]    idx;
    logic [8:0]    row_q;
    logic [7:0]    tx_hold;
    logic          seen_rise;
    logic [TW-1:0] timer;
    logic [1:0]    retry_cnt;
    logic          done_q;
    logic          error_q;

    logic          busy_fall;
    logic          is_payload;
    logic [7:0]    cur_byte;
    logic          rx_ack;
    logic          rx_nak;
    logic          timed_out;
    logic          can_retry;
    logic          byte_handed;

    neg u_busy_fall (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (tx_busy),
        .fall  (busy_fall)
    );

    always_comb begin
        is_payload  = (idx >= 8'd2) && (idx < LAST_IDX);
        rx_ack      = rx_done && (rx_data == SUCCESSFULLY_RECEIVED);
        rx_nak      = rx_done && (rx_data == NOT_ALL_RECEIVED);
        timed_out   = (timer == TIMER_LAST);
        can_retry   = (int'(retry_cnt) + 1) < MAX_RETRY;
        byte_handed = seen_rise && busy_fall;

        if (idx == 8'd0) begin
            cur_byte = row_byte(row_q, 1'b1);
        end else if (idx == 8'd1) begin
            cur_byte = row_byte(row_q, 1'b0);
        end else if (idx == LAST_IDX) begin
            cur_byte = END_WORD;
        end else begin
            cur_byte = rd_data;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = LOAD;
            LOAD:     state_next = SEND;
            SEND:     if (!tx_busy) state_next = WAIT_TX;
            WAIT_TX:  if (byte_handed) state_next = (idx == LAST_IDX) ? WAIT_ACK : LOAD;
            WAIT_ACK: begin
                // A valid response wins over a timeout expiring in the same cycle.
                if (rx_ack) begin
                    state_next = IDLE;
                end else if (rx_nak || timed_out) begin
                    state_next = can_retry ? LOAD : IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    // The address is held through SEND so rd_data stays valid if SEND stalls.
    always_comb begin
        rd_addr  = ((state == LOAD || state == SEND) && is_payload) ? (idx - 8'd2) : 8'd0;
        tx_start = (state == SEND) && !tx_busy;
        tx_data  = tx_start ? cur_byte : tx_hold;
        busy     = (state != IDLE);
        done     = done_q;
        error    = error_q;
        retries  = retry_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 8'd0;
            row_q     <= 9'd0;
            tx_hold   <= 8'd0;
            seen_rise <= 1'b0;
            timer     <= '0;
            retry_cnt <= 2'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state   <= state_next;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        row_q     <= row;
                        idx       <= 8'd0;
                        retry_cnt <= 2'd0;
                    end
                end
                SEND: begin
                    if (tx_start) begin
                        tx_hold   <= cur_byte;
                        seen_rise <= 1'b0;
                    end
                end
                WAIT_TX: begin
                    if (tx_busy) begin
                        seen_rise <= 1'b1;
                    end
                    if (byte_handed) begin
                        if (idx != LAST_IDX) begin
                            idx <= idx + 8'd1;
                        end else begin
                            timer <= '0;
                        end
                    end
                end
                WAIT_ACK: begin
                    timer <= timer + 1'b1;
                    if (rx_ack) begin
                        done_q <= 1'b1;
                    end else if (rx_nak || timed_out) begin
                        if (can_retry) begin
                            retry_cnt <= retry_cnt + 2'd1;
                            idx       <= 8'd0;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_row_sender.sv
// tb_uart_row_sender: directed scenarios for uart_row_sender with a byte
// scoreboard, a payload buffer model and a transmitter model.
module tb_uart_row_sender;

    localparam int PAYLOAD = 240;
    localparam int FRAME   = PAYLOAD + 3;
    localparam int TIMEOUT = 1000;
    localparam int FRAME_BUDGET = 4000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] row;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] retries;

    logic [7:0] mem [PAYLOAD];
    logic [7:0] exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Transmitter-model bookkeeping.
    int bytes_sent   = 0;
    int frame_count  = 0;
    int done_count   = 0;
    int error_count  = 0;
    int end_fall_cyc = 0;
    int err_cyc      = 0;
    int pos          = 0;
    bit end_pending  = 1'b0;
    bit pend         = 1'b0;
    int busy_left    = 0;
    int timeout_lat  = TIMEOUT + 1;

    uart_row_sender #(
        .PAYLOAD_BYTES (PAYLOAD),
        .ACK_TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .row      (row),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .retries  (retries)
    );

    // ---------------- clock / reset / buffer ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rd_data <= mem[rd_addr];

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- transmitter model + scoreboard ----------------
    // Busy rises the cycle after tx_start and stays high 2..5 cycles.
    initial begin : tx_model
        logic [7:0] exp;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n !== 1'b1) begin
                exp_q.delete();
                pos = 0;
                end_pending = 1'b0;
            end
            if (done === 1'b1 || error === 1'b1) begin
                checks++;
                if (done === 1'b1 && error === 1'b1) begin
                    failures++;
                    $display("FAIL done_error_exclusive: done=%b error=%b both high at cyc %0d", done, error, cyc);
                end
                if (done === 1'b1) done_count++;
                if (error === 1'b1) begin
                    error_count++;
                    err_cyc = cyc;
                end
            end
            if (tx_start === 1'b1) begin
                checks++;
                if (tx_busy !== 1'b0 || pend || busy_left > 0) begin
                    failures++;
                    $display("FAIL tx_start_overlap: tx_start while transmitter busy at cyc %0d", cyc);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got %02h, expected no byte", tx_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (tx_data !== exp) begin
                        failures++;
                        $display("FAIL tx_byte pos %0d: got %02h expected %02h", pos, tx_data, exp);
                    end
                end
                bytes_sent++;
                pos++;
                if (pos == FRAME) begin
                    pos = 0;
                    end_pending = 1'b1;
                end
                pend = 1'b1;
            end else if (pend) begin
                pend = 1'b0;
                tx_busy = 1'b1;
                busy_left = $urandom_range(2, 5);
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy = 1'b0;
                    if (end_pending) begin
                        end_pending = 1'b0;
                        frame_count++;
                        end_fall_cyc = cyc;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_mem(input logic [7:0] pat);
        for (int i = 0; i < PAYLOAD; i++) mem[i] = 8'(i) ^ pat;
    endtask

    task automatic push_frame(input logic [8:0] r);
        exp_q.push_back({7'b0, r[8]});
        exp_q.push_back(r[7:0]);
        for (int i = 0; i < PAYLOAD; i++) exp_q.push_back(mem[i]);
        exp_q.push_back(8'hDD);
    endtask

    task automatic pulse_start(input logic [8:0] r);
        @(negedge clk);
        start = 1'b1;
        row   = r;
        @(negedge clk);
        start = 1'b0;
        row   = 9'd0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frame_count < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (frame_count < target) begin
            failures++;
            $display("FAIL wait_frames: frames=%0d expected %0d within %0d cycles", frame_count, target, budget);
        end
        // Let the DUT settle into WAIT_ACK before any response is driven.
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int n;
        n = 0;
        while (bytes_sent < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bytes_sent < target) begin
            failures++;
            $display("FAIL wait_bytes: bytes=%0d expected %0d within %0d cycles", bytes_sent, target, budget);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({busy, done, error, tx_start, tx_data, rd_addr, retries} !== 21'd0) begin
            failures++;
            $display("FAIL %s: busy=%b done=%b error=%b tx_start=%b tx_data=%02h rd_addr=%02h retries=%0d, all required 0",
                     tag, busy, done, error, tx_start, tx_data, rd_addr, retries);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; row = 9'h1FF; rx_data = 8'h00; rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        @(negedge clk);
        start = 1'b0; row = 9'd0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bytes_sent != 0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b bytes=%0d, required 0 and 0", busy, bytes_sent);
        end
    endtask

    task automatic test_single_ack();
        int b0, f0, d0, e0;
        b0 = bytes_sent; f0 = frame_count; d0 = done_count; e0 = error_count;
        fill_mem(8'h00);
        push_frame(9'h1A5);
        pulse_start(9'h1A5);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ack_busy_set: busy=%b required 1", busy);
        end
        wait_frames(f0 + 1, FRAME_BUDGET);
        checks++;
        if (busy !== 1'b1 || done_count != d0) begin
            failures++;
            $display("FAIL ack_waiting: busy=%b done_pulses=%0d, required 1 and 0", busy, done_count - d0);
        end
        @(negedge clk);
        rx_data = 8'hFF; rx_done = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ack_done_timing: done=%b busy=%b, required 1 and 0", done, busy);
        end
        @(negedge clk);
        rx_done = 1'b0; rx_data = 8'h00;
        repeat (5) @(negedge clk);
        checks++;
        if (done_count - d0 != 1 || error_count != e0 || retries !== 2'd0 ||
            bytes_sent - b0 != FRAME || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ack_summary: done=%0d error=%0d retries=%0d bytes=%0d left=%0d, required 1 0 0 %0d 0",
                     done_count - d0, error_count - e0, retries, bytes_sent - b0, exp_q.size(), FRAME);
        end
    endtask

    task automatic test_nak_retry();
        int b0, f0, d0, e0;
        b0 = bytes_sent; f0 = frame_count; d0 = done_count; e0 = error_count;
        fill_mem(8'h3C);
        push_frame(9'h0F0);
        push_frame(9'h0F0);
        pulse_start(9'h0F0);
        wait_frames(f0 + 1, FRAME_BUDGET);
        send_rx(8'h11);
        checks++;
        if (retries !== 2'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL nak_retries: retries=%0d busy=%b, required 1 and 1", retries, busy);
        end
        wait_frames(f0 + 2, FRAME_BUDGET);
        send_rx(8'hFF);
        repeat (5) @(negedge clk);
        checks++;
        if (done_count - d0 != 1 || error_count != e0 || retries !== 2'd1 ||
            bytes_sent - b0 != 2 * FRAME || exp_q.size() != 0) begin
            failures++;
            $display("FAIL nak_summary: done=%0d error=%0d retries=%0d bytes=%0d left=%0d, required 1 0 1 %0d 0",
                     done_count - d0, error_count - e0, retries, bytes_sent - b0, exp_q.size(), 2 * FRAME);
        end
    endtask

    task automatic test_timeout();
        int b0, f0, d0, e0, n, lat;
        b0 = bytes_sent; f0 = frame_count; d0 = done_count; e0 = error_count;
        fill_mem(8'h81);
        for (int k = 0; k < 3; k++) push_frame(9'h155);
        pulse_start(9'h155);
        wait_frames(f0 + 3, 3 * FRAME_BUDGET + 3 * TIMEOUT);
        n = 0;
        while (error_count == e0 && n < 2 * TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        lat = err_cyc - end_fall_cyc;
        checks++;
        if (error_count == e0 || lat < TIMEOUT - 5 || lat > TIMEOUT + 10) begin
            failures++;
            $display("FAIL timeout_latency: error after %0d cycles, required about %0d", lat, TIMEOUT);
        end else begin
            timeout_lat = lat;
        end
        repeat (50) @(negedge clk);
        checks++;
        if (error_count - e0 != 1 || done_count != d0 || retries !== 2'd2 || busy !== 1'b0 ||
            bytes_sent - b0 != 3 * FRAME || exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_summary: error=%0d done=%0d retries=%0d busy=%b bytes=%0d left=%0d, required 1 0 2 0 %0d 0",
                     error_count - e0, done_count - d0, retries, busy, bytes_sent - b0, exp_q.size(), 3 * FRAME);
        end
    endtask

    task automatic test_ignore();
        int b0, f0, d0, e0;
        b0 = bytes_sent; f0 = frame_count; d0 = done_count; e0 = error_count;
        fill_mem(8'h47);
        push_frame(9'h0AB);
        pulse_start(9'h0AB);
        checks++;
        if (retries !== 2'd0) begin
            failures++;
            $display("FAIL retries_cleared: retries=%0d required 0", retries);
        end
        wait_bytes(b0 + 1, 100);
        pulse_start(9'h003);
        wait_bytes(b0 + 50, FRAME_BUDGET);
        send_rx(8'hFF);
        checks++;
        if (busy !== 1'b1 || done_count != d0) begin
            failures++;
            $display("FAIL ignore_midframe_rx: busy=%b done_pulses=%0d, required 1 and 0", busy, done_count - d0);
        end
        wait_frames(f0 + 1, FRAME_BUDGET);
        send_rx(8'h55);
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done_count != d0 || error_count != e0 || retries !== 2'd0) begin
            failures++;
            $display("FAIL ignore_stray_rx: busy=%b done=%0d error=%0d retries=%0d, required 1 0 0 0",
                     busy, done_count - d0, error_count - e0, retries);
        end
        send_rx(8'hFF);
        repeat (5) @(negedge clk);
        checks++;
        if (done_count - d0 != 1 || bytes_sent - b0 != FRAME || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ignore_summary: done=%0d bytes=%0d left=%0d, required 1 %0d 0",
                     done_count - d0, bytes_sent - b0, exp_q.size(), FRAME);
        end
    endtask

    task automatic test_reset_midframe();
        int b0, b1, f0, d0;
        b0 = bytes_sent;
        fill_mem(8'h99);
        push_frame(9'h077);
        pulse_start(9'h077);
        // Frame byte 102 is payload byte 100.
        wait_bytes(b0 + 103, FRAME_BUDGET);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_midframe_outputs");
        b1 = bytes_sent;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (bytes_sent != b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_tx: extra bytes=%0d busy=%b, required 0 and 0", bytes_sent - b1, busy);
        end
        b0 = bytes_sent; f0 = frame_count; d0 = done_count;
        fill_mem(8'hC3);
        push_frame(9'h1FF);
        pulse_start(9'h1FF);
        wait_frames(f0 + 1, FRAME_BUDGET);
        send_rx(8'hFF);
        repeat (5) @(negedge clk);
        checks++;
        if (done_count - d0 != 1 || retries !== 2'd0 || bytes_sent - b0 != FRAME || exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_clean_frame: done=%0d retries=%0d bytes=%0d left=%0d, required 1 0 %0d 0",
                     done_count - d0, retries, bytes_sent - b0, exp_q.size(), FRAME);
        end
    endtask

    task automatic test_coincident();
        int b0, f0, d0, e0, target, n;
        b0 = bytes_sent; f0 = frame_count; d0 = done_count; e0 = error_count;
        fill_mem(8'h5A);
        push_frame(9'h100);
        pulse_start(9'h100);
        wait_frames(f0 + 1, FRAME_BUDGET);
        // The cycle whose closing edge sees the timeout expire.
        target = end_fall_cyc + timeout_lat - 1;
        n = 0;
        while (cyc < target && n < 2 * TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        rx_data = 8'hFF; rx_done = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL coincident_priority: done=%b error=%b, required 1 and 0", done, error);
        end
        @(negedge clk);
        rx_done = 1'b0; rx_data = 8'h00;
        repeat (30) @(negedge clk);
        checks++;
        if (done_count - d0 != 1 || error_count != e0 || retries !== 2'd0 ||
            bytes_sent - b0 != FRAME || exp_q.size() != 0) begin
            failures++;
            $display("FAIL coincident_summary: done=%0d error=%0d retries=%0d bytes=%0d left=%0d, required 1 0 0 %0d 0",
                     done_count - d0, error_count - e0, retries, bytes_sent - b0, exp_q.size(), FRAME);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin : main
        test_reset();
        test_single_ack();
        test_nak_retry();
        test_timeout();
        test_ignore();
        test_reset_midframe();
        test_coincident();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
